// File: rtl/avaliador_jogada.sv
// avaliador_jogada: grades one expected note (pitch + duration) against the
// encoded keyboard and keeps a score (errors, current and best streak).
module avaliador_jogada #(
  parameter int NOTA_W        = 4,
  parameter int TEMPO_W       = 4,
  parameter int TOL           = 1,
  parameter int TIMEOUT_TICKS = 8,
  parameter int ERRO_W        = 3,
  parameter int MAX_ERROS     = 3,
  parameter int SEQ_W         = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inicia,
  input  logic [NOTA_W-1:0]   nota_esperada,
  input  logic [TEMPO_W-1:0]  tempo_esperado,
  input  logic                tick,
  input  logic [NOTA_W-1:0]   nota_tocada,
  input  logic                zera_placar,
  output logic                ocupado,
  output logic                pronto,
  output logic                acerto,
  output logic                erro_nota,
  output logic                erro_tempo,
  output logic                timeout,
  output logic [ERRO_W-1:0]   erros,
  output logic [SEQ_W-1:0]    sequencia,
  output logic [SEQ_W-1:0]    max_sequencia,
  output logic                perdeu
);

  // Counter must hold both the timeout limit and the longest gradable hold.
  localparam int TEMPO_LIM = (1 << TEMPO_W) - 1 + TOL;
  localparam int CNT_MAX   = (TIMEOUT_TICKS > TEMPO_LIM) ? TIMEOUT_TICKS : TEMPO_LIM;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int CX        = CW + 1;
  localparam int EX        = ERRO_W + 1;

  localparam logic [CX-1:0] TOL_X       = CX'(TOL);
  localparam logic [CX-1:0] TIMEOUT_X   = CX'(TIMEOUT_TICKS);
  localparam logic [EX-1:0] MAX_ERROS_X = EX'(MAX_ERROS);

  typedef enum logic [1:0] {
    OCIOSO,
    ESPERA,
    SEGURA,
    RESULTADO
  } estado_t;

  estado_t             estado_q, estado_d;
  logic [NOTA_W-1:0]   nota_prev_q;
  logic [NOTA_W-1:0]   nota_esp_q, nota_esp_d;
  logic [TEMPO_W-1:0]  tempo_esp_q, tempo_esp_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                acerto_q, acerto_d;
  logic                erro_nota_q, erro_nota_d;
  logic                erro_tempo_q, erro_tempo_d;
  logic                timeout_q, timeout_d;
  logic [ERRO_W-1:0]   erros_q, erros_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [SEQ_W-1:0]    max_q, max_d;

  logic                press;
  logic                soltou;
  logic                ev_acerto;
  logic                ev_erro;
  logic [CW-1:0]       cnt_sat;
  logic [CX-1:0]       cnt_x;
  logic [CX-1:0]       cnt_inc_x;
  logic [CX-1:0]       cnt_sat_x;
  logic [CX-1:0]       tempo_x;
  logic [CX-1:0]       limite_x;
  logic [CX-1:0]       desvio_x;
  logic                dentro_tol;
  logic [SEQ_W-1:0]    seq_inc;

  // A press is a rising edge of "any key down"; a key held across inicia is not one.
  assign press  = (nota_tocada != '0) && (nota_prev_q == '0);
  assign soltou = (nota_tocada != nota_esp_q);

  // All duration arithmetic is done one bit wider than the counter so nothing wraps.
  assign cnt_x      = {1'b0, cnt_q};
  assign cnt_inc_x  = cnt_x + CX'(1);
  assign cnt_sat    = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  assign cnt_sat_x  = {1'b0, cnt_sat};
  assign tempo_x    = CX'(tempo_esp_q);
  assign limite_x   = tempo_x + TOL_X;
  assign desvio_x   = (cnt_x >= tempo_x) ? (cnt_x - tempo_x) : (tempo_x - cnt_x);
  assign dentro_tol = (desvio_x <= TOL_X);

  // State, latched expectations, hold counter and result flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      nota_prev_q  <= '0;
      nota_esp_q   <= '0;
      tempo_esp_q  <= '0;
      cnt_q        <= '0;
      acerto_q     <= 1'b0;
      erro_nota_q  <= 1'b0;
      erro_tempo_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      nota_prev_q  <= nota_tocada;
      nota_esp_q   <= nota_esp_d;
      tempo_esp_q  <= tempo_esp_d;
      cnt_q        <= cnt_d;
      acerto_q     <= acerto_d;
      erro_nota_q  <= erro_nota_d;
      erro_tempo_q <= erro_tempo_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next state and grading decision; ev_* mark the edge at which a result is produced.
  always_comb begin
    estado_d     = estado_q;
    nota_esp_d   = nota_esp_q;
    tempo_esp_d  = tempo_esp_q;
    cnt_d        = cnt_q;
    acerto_d     = acerto_q;
    erro_nota_d  = erro_nota_q;
    erro_tempo_d = erro_tempo_q;
    timeout_d    = timeout_q;
    ev_acerto    = 1'b0;
    ev_erro      = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (inicia) begin
          nota_esp_d   = nota_esperada;
          tempo_esp_d  = tempo_esperado;
          cnt_d        = '0;
          acerto_d     = 1'b0;
          erro_nota_d  = 1'b0;
          erro_tempo_d = 1'b0;
          timeout_d    = 1'b0;
          estado_d     = ESPERA;
        end
      end

      ESPERA: begin
        // A press outranks a timeout tick arriving in the same cycle.
        if (press) begin
          if (nota_tocada == nota_esp_q) begin
            cnt_d    = '0;
            estado_d = SEGURA;
          end else begin
            erro_nota_d = 1'b1;
            ev_erro     = 1'b1;
            estado_d    = RESULTADO;
          end
        end else if (tick) begin
          if (cnt_inc_x >= TIMEOUT_X) begin
            timeout_d = 1'b1;
            ev_erro   = 1'b1;
            estado_d  = RESULTADO;
          end else begin
            cnt_d = cnt_inc_x[CW-1:0];
          end
        end
      end

      SEGURA: begin
        // Release is graded on the count before any tick of the same cycle.
        if (soltou) begin
          if (dentro_tol) begin
            acerto_d  = 1'b1;
            ev_acerto = 1'b1;
          end else begin
            erro_tempo_d = 1'b1;
            ev_erro      = 1'b1;
          end
          estado_d = RESULTADO;
        end else if (tick) begin
          if (cnt_sat_x > limite_x) begin
            erro_tempo_d = 1'b1;
            ev_erro      = 1'b1;
            estado_d     = RESULTADO;
          end else begin
            cnt_d = cnt_sat;
          end
        end
      end

      RESULTADO: begin
        estado_d = OCIOSO;
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // Score registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      erros_q <= '0;
      seq_q   <= '0;
      max_q   <= '0;
    end else begin
      erros_q <= erros_d;
      seq_q   <= seq_d;
      max_q   <= max_d;
    end
  end

  // Score update on a result; a clear request wins over a simultaneous result.
  always_comb begin
    erros_d = erros_q;
    seq_d   = seq_q;
    max_d   = max_q;
    seq_inc = (seq_q == '1) ? seq_q : seq_q + SEQ_W'(1);

    if (zera_placar) begin
      erros_d = '0;
      seq_d   = '0;
      max_d   = '0;
    end else if (ev_acerto) begin
      seq_d = seq_inc;
      if (seq_inc > max_q) begin
        max_d = seq_inc;
      end
    end else if (ev_erro) begin
      if (erros_q != '1) begin
        erros_d = erros_q + ERRO_W'(1);
      end
      seq_d = '0;
    end
  end

  assign ocupado       = (estado_q != OCIOSO);
  assign pronto        = (estado_q == RESULTADO);
  assign acerto        = acerto_q;
  assign erro_nota     = erro_nota_q;
  assign erro_tempo    = erro_tempo_q;
  assign timeout       = timeout_q;
  assign erros         = erros_q;
  assign sequencia     = seq_q;
  assign max_sequencia = max_q;
  assign perdeu        = ({1'b0, erros_q} >= MAX_ERROS_X);

endmodule

// File: tb/tb_avaliador_jogada.sv
// Testbench for avaliador_jogada: scenario tasks push expected results to a
// scoreboard queue; a negedge monitor pops and compares on every pronto.
module tb_avaliador_jogada;

  logic       clock = 1'b0;
  logic       reset;
  logic       inicia;
  logic [3:0] nota_esperada;
  logic [3:0] tempo_esperado;
  logic       tick;
  logic [3:0] nota_tocada;
  logic       zera_placar;
  logic       ocupado, pronto, acerto, erro_nota, erro_tempo, timeout;
  logic [2:0] erros;
  logic [4:0] sequencia, max_sequencia;
  logic       perdeu;

  avaliador_jogada #(
    .NOTA_W(4), .TEMPO_W(4), .TOL(1), .TIMEOUT_TICKS(8),
    .ERRO_W(3), .MAX_ERROS(3), .SEQ_W(5)
  ) dut (
    .clock(clock), .reset(reset), .inicia(inicia),
    .nota_esperada(nota_esperada), .tempo_esperado(tempo_esperado),
    .tick(tick), .nota_tocada(nota_tocada), .zera_placar(zera_placar),
    .ocupado(ocupado), .pronto(pronto), .acerto(acerto),
    .erro_nota(erro_nota), .erro_tempo(erro_tempo), .timeout(timeout),
    .erros(erros), .sequencia(sequencia), .max_sequencia(max_sequencia),
    .perdeu(perdeu)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit       a, en, et, to;
    bit [2:0] erros;
    bit [4:0] seq, maxs;
    bit       perdeu;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   m_erros = 0, m_seq = 0, m_max = 0;

  // Scoreboard side: every pronto must match the oldest pending expectation.
  always @(negedge clock) begin
    if (pronto === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pronto: got pronto=1 required no pending result");
      end else begin
        mon_e = sb.pop_front();
        if ({acerto, erro_nota, erro_tempo, timeout} !== {mon_e.a, mon_e.en, mon_e.et, mon_e.to}) begin
          errors++;
          $display("FAIL sb_flags: got %b required %b", {acerto, erro_nota, erro_tempo, timeout},
                   {mon_e.a, mon_e.en, mon_e.et, mon_e.to});
        end
        checks++;
        if (erros !== mon_e.erros) begin
          errors++;
          $display("FAIL sb_erros: got %0d required %0d", erros, mon_e.erros);
        end
        checks++;
        if (sequencia !== mon_e.seq) begin
          errors++;
          $display("FAIL sb_sequencia: got %0d required %0d", sequencia, mon_e.seq);
        end
        checks++;
        if (max_sequencia !== mon_e.maxs) begin
          errors++;
          $display("FAIL sb_max_sequencia: got %0d required %0d", max_sequencia, mon_e.maxs);
        end
        checks++;
        if (perdeu !== mon_e.perdeu) begin
          errors++;
          $display("FAIL sb_perdeu: got %b required %b", perdeu, mon_e.perdeu);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [3:0] n, input logic [3:0] t);
    nota_esperada  = n;
    tempo_esperado = t;
    inicia = 1'b1;
    cyc();
    inicia = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask

  // Score model and scoreboard push for a result decided at the next edge.
  task automatic push_expected(input bit a, input bit en, input bit et, input bit to, input bit zera);
    exp_t e;
    if (a) begin
      if (m_seq < 31) m_seq++;
      if (m_seq > m_max) m_max = m_seq;
    end else begin
      if (m_erros < 7) m_erros++;
      m_seq = 0;
    end
    if (zera) begin
      m_erros = 0; m_seq = 0; m_max = 0;
    end
    e.a = a; e.en = en; e.et = et; e.to = to;
    e.erros  = 3'(m_erros);
    e.seq    = 5'(m_seq);
    e.maxs   = 5'(m_max);
    e.perdeu = (m_erros >= 3);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1; inicia = 1'b0; tick = 1'b0; zera_placar = 1'b0;
    nota_esperada = '0; tempo_esperado = '0; nota_tocada = '0;
    repeat (2) cyc();
    reset = 1'b0;
    checks++;
    if ({ocupado, pronto} !== 2'b00) begin
      errors++; $display("FAIL reset_ctrl: got %b required 00", {ocupado, pronto});
    end
    checks++;
    if ({acerto, erro_nota, erro_tempo, timeout} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b required 0000", {acerto, erro_nota, erro_tempo, timeout});
    end
    checks++;
    if ({erros, sequencia, max_sequencia, perdeu} !== 14'd0) begin
      errors++; $display("FAIL reset_score: got %0d/%0d/%0d/%b required 0/0/0/0",
                         erros, sequencia, max_sequencia, perdeu);
    end
  endtask

  task automatic test_acerto();
    start(4'd5, 4'd4);
    checks++;
    if (ocupado !== 1'b1) begin errors++; $display("FAIL acerto_ocupado: got %b required 1", ocupado); end
    nota_tocada = 4'd5;
    cyc();
    do_ticks(4);
    push_expected(1, 0, 0, 0, 0);
    nota_tocada = 4'd0;
    cyc();
    checks++;
    if (pronto !== 1'b1) begin errors++; $display("FAIL acerto_latency: got pronto=%b required 1", pronto); end
    cyc();
    checks++;
    if ({ocupado, pronto, acerto} !== 3'b001) begin
      errors++; $display("FAIL acerto_hold: got ocupado,pronto,acerto=%b required 001", {ocupado, pronto, acerto});
    end
  endtask

  task automatic test_tolerancia();
    int held[4] = '{3, 5, 2, 5};
    bit tk[4]   = '{0, 0, 0, 1};
    bit ok[4]   = '{1, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      start(4'd5, 4'd4);
      nota_tocada = 4'd5;
      cyc();
      do_ticks(held[i]);
      push_expected(ok[i], 0, !ok[i], 0, 0);
      nota_tocada = 4'd0;
      tick = tk[i];
      cyc();
      tick = 1'b0;
      checks++;
      if (pronto !== 1'b1) begin errors++; $display("FAIL tol_pronto[%0d]: got %b required 1", i, pronto); end
      cyc();
    end
    // Held past tempo+TOL: graded on the sixth tick without waiting for release.
    start(4'd5, 4'd4);
    nota_tocada = 4'd5;
    cyc();
    do_ticks(5);
    checks++;
    if ({ocupado, pronto} !== 2'b10) begin
      errors++; $display("FAIL overhold_wait: got ocupado,pronto=%b required 10", {ocupado, pronto});
    end
    push_expected(0, 0, 1, 0, 0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++;
    if (pronto !== 1'b1) begin errors++; $display("FAIL overhold_pronto: got %b required 1", pronto); end
    cyc();
    nota_tocada = 4'd0;
    cyc();
  endtask

  task automatic test_erro_nota_timeout();
    start(4'd5, 4'd4);
    push_expected(0, 1, 0, 0, 0);
    nota_tocada = 4'd7;
    cyc();
    checks++;
    if (pronto !== 1'b1) begin errors++; $display("FAIL erro_nota_pronto: got %b required 1", pronto); end
    cyc();
    nota_tocada = 4'd0;
    cyc();
    start(4'd5, 4'd4);
    do_ticks(7);
    checks++;
    if ({ocupado, pronto} !== 2'b10) begin
      errors++; $display("FAIL timeout_early: got ocupado,pronto=%b required 10", {ocupado, pronto});
    end
    push_expected(0, 0, 0, 1, 0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++;
    if (pronto !== 1'b1) begin errors++; $display("FAIL timeout_pronto: got %b required 1", pronto); end
    cyc();
    // Press on the eighth tick beats the timeout.
    start(4'd5, 4'd4);
    do_ticks(7);
    nota_tocada = 4'd5;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++;
    if ({ocupado, pronto} !== 2'b10) begin
      errors++; $display("FAIL press_beats_timeout: got ocupado,pronto=%b required 10", {ocupado, pronto});
    end
    do_ticks(4);
    push_expected(1, 0, 0, 0, 0);
    nota_tocada = 4'd0;
    cyc();
    checks++;
    if (pronto !== 1'b1) begin errors++; $display("FAIL press_tick_acerto: got pronto=%b required 1", pronto); end
    cyc();
  endtask

  task automatic test_erros_saturacao();
    int exp_e;
    zera_placar = 1'b1;
    cyc();
    zera_placar = 1'b0;
    m_erros = 0; m_seq = 0; m_max = 0;
    checks++;
    if ({erros, sequencia, max_sequencia} !== 13'd0) begin
      errors++; $display("FAIL zera_idle: got %0d/%0d/%0d required 0/0/0", erros, sequencia, max_sequencia);
    end
    for (int i = 0; i < 8; i++) begin
      start(4'd5, 4'd4);
      push_expected(0, 1, 0, 0, 0);
      nota_tocada = 4'd7;
      cyc();
      exp_e = (i + 1 > 7) ? 7 : i + 1;
      checks++;
      if (erros !== 3'(exp_e) || perdeu !== (i >= 2)) begin
        errors++; $display("FAIL erros_step[%0d]: got erros=%0d perdeu=%b required %0d %b",
                           i, erros, perdeu, exp_e, (i >= 2));
      end
      cyc();
      nota_tocada = 4'd0;
      cyc();
    end
  endtask

  task automatic test_sequencia();
    bit ok[5]      = '{1, 1, 1, 0, 1};
    int seq_exp[5] = '{1, 2, 3, 0, 1};
    zera_placar = 1'b1;
    cyc();
    zera_placar = 1'b0;
    m_erros = 0; m_seq = 0; m_max = 0;
    for (int i = 0; i < 5; i++) begin
      start(4'd5, 4'd4);
      nota_tocada = 4'd5;
      cyc();
      do_ticks(ok[i] ? 4 : 2);
      push_expected(ok[i], 0, !ok[i], 0, 0);
      nota_tocada = 4'd0;
      cyc();
      checks++;
      if (sequencia !== 5'(seq_exp[i])) begin
        errors++; $display("FAIL seq_step[%0d]: got %0d required %0d", i, sequencia, seq_exp[i]);
      end
      cyc();
    end
    checks++;
    if (max_sequencia !== 5'd3) begin
      errors++; $display("FAIL seq_max: got %0d required 3", max_sequencia);
    end
    // Clear request on the grading edge overrides the acerto update.
    start(4'd5, 4'd4);
    nota_tocada = 4'd5;
    cyc();
    do_ticks(4);
    push_expected(1, 0, 0, 0, 1);
    nota_tocada = 4'd0;
    zera_placar = 1'b1;
    cyc();
    zera_placar = 1'b0;
    checks++;
    if ({pronto, acerto, erros, sequencia, max_sequencia} !== {2'b11, 13'd0}) begin
      errors++; $display("FAIL zera_vs_acerto: got pronto=%b acerto=%b %0d/%0d/%0d required 1 1 0/0/0",
                         pronto, acerto, erros, sequencia, max_sequencia);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    start(4'd5, 4'd4);
    push_expected(0, 1, 0, 0, 0);
    nota_tocada = 4'd3;
    cyc();
    checks++;
    if (pronto !== 1'b1) begin errors++; $display("FAIL b2b_pronto: got %b required 1", pronto); end
    inicia = 1'b1;
    cyc();
    inicia = 1'b0;
    checks++;
    if (ocupado !== 1'b0) begin errors++; $display("FAIL b2b_inicia_on_pronto: got ocupado=%b required 0", ocupado); end
    nota_tocada = 4'd0;
    start(4'd2, 4'd1);
    nota_tocada = 4'd2;
    cyc();
    do_ticks(1);
    push_expected(1, 0, 0, 0, 0);
    nota_tocada = 4'd0;
    cyc();
    checks++;
    if ({pronto, acerto} !== 2'b11) begin
      errors++; $display("FAIL b2b_second: got pronto,acerto=%b required 11", {pronto, acerto});
    end
    cyc();
  endtask

  task automatic test_tecla_presa_reset();
    nota_tocada = 4'd5;
    cyc();
    start(4'd5, 4'd4);
    do_ticks(2);
    nota_tocada = 4'd0;
    cyc();
    checks++;
    if ({ocupado, pronto} !== 2'b10) begin
      errors++; $display("FAIL held_key_not_press: got ocupado,pronto=%b required 10", {ocupado, pronto});
    end
    nota_tocada = 4'd5;
    cyc();
    do_ticks(2);
    inicia = 1'b1; nota_esperada = 4'd3; tempo_esperado = 4'd1;
    cyc();
    inicia = 1'b0; nota_esperada = 4'd5; tempo_esperado = 4'd4;
    do_ticks(2);
    push_expected(1, 0, 0, 0, 0);
    nota_tocada = 4'd0;
    cyc();
    checks++;
    if ({pronto, acerto} !== 2'b11) begin
      errors++; $display("FAIL inicia_in_segura: got pronto,acerto=%b required 11", {pronto, acerto});
    end
    cyc();
    start(4'd5, 4'd4);
    nota_tocada = 4'd5;
    cyc();
    do_ticks(2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m_erros = 0; m_seq = 0; m_max = 0;
    checks++;
    if ({ocupado, pronto, acerto, erro_nota, erro_tempo, timeout, erros, sequencia, max_sequencia, perdeu} !== 20'd0) begin
      errors++; $display("FAIL reset_mid_segura: got %b%b %b%b%b%b %0d/%0d/%0d %b required all 0",
                         ocupado, pronto, acerto, erro_nota, erro_tempo, timeout,
                         erros, sequencia, max_sequencia, perdeu);
    end
    nota_tocada = 4'd0;
    cyc();
    cyc();
    checks++;
    if ({ocupado, pronto} !== 2'b00) begin
      errors++; $display("FAIL reset_no_pronto: got ocupado,pronto=%b required 00", {ocupado, pronto});
    end
  endtask

  initial begin
    test_reset();
    test_acerto();
    test_tolerancia();
    test_erro_nota_timeout();
    test_erros_saturacao();
    test_sequencia();
    test_back_to_back();
    test_tecla_presa_reset();
    cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d pending results required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
